// File: rtl/fifo_rptr_empty_pkg.sv
// Shared defaults for the async FIFO read-side pointer stage.
// Holds the default address width and almost-empty threshold used by the
// interface and the top; the write-side pointer stage reuses these values.
package fifo_rptr_empty_pkg;

    localparam int unsigned ADDR_WIDTH_DEF          = 4;
    localparam int unsigned ALMOST_EMPTY_THRESH_DEF = 2;

endpackage : fifo_rptr_empty_pkg

// File: rtl/fifo_rptr_empty_if.sv
// Read-side bus of the async FIFO.
// Signals: rd_en, wptr_sync (consumer/synchronizer -> pointer stage);
//          raddr, rptr, empty, rd_level, underflow, almost_empty (pointer stage -> consumer).
// Optional: almost_empty exists only when FIFO_ALMOST_EMPTY_EN is defined.
interface fifo_rptr_empty_if
    import fifo_rptr_empty_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);
    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic            rd_en;
    logic [PW-1:0]   wptr_sync;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [PW-1:0]   rptr;
    logic            empty;
    logic [PW-1:0]   rd_level;
    logic            underflow;
`ifdef FIFO_ALMOST_EMPTY_EN
    logic            almost_empty;
`endif

    // Consumer side: issues reads, observes pointers and status.
    modport master (
        output rd_en,
        output wptr_sync,
        input  raddr,
        input  rptr,
        input  empty,
        input  rd_level,
`ifdef FIFO_ALMOST_EMPTY_EN
        input  almost_empty,
`endif
        input  underflow
    );

    // Pointer stage side.
    modport slave (
        input  rd_en,
        input  wptr_sync,
        output raddr,
        output rptr,
        output empty,
        output rd_level,
`ifdef FIFO_ALMOST_EMPTY_EN
        output almost_empty,
`endif
        output underflow
    );

endinterface : fifo_rptr_empty_if

// File: rtl/fifo_rptr_empty_gray_to_bin.sv
// Combinational gray-to-binary converter (XOR prefix from the MSB down).
// Ports: gray (in, WIDTH), bin (out, WIDTH).
module gray_to_bin #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Log-step prefix XOR: after the loop bit i holds XOR of gray[WIDTH-1:i].
    always_comb begin
        logic [WIDTH-1:0] acc;
        acc = gray;
        for (int unsigned s = 1; s < WIDTH; s = s << 1) begin
            acc = acc ^ (acc >> s);
        end
        bin = acc;
    end

endmodule : gray_to_bin

// File: rtl/fifo_rptr_empty.sv
// Read-domain pointer and status stage of the asynchronous FIFO.
// Ports: clk, rst (synchronous, active-low); bus (slave modport of
//        fifo_rptr_empty_if): rd_en, wptr_sync in; raddr, rptr, empty,
//        rd_level, underflow (and almost_empty) out, all registered.
// Optional feature macro: FIFO_ALMOST_EMPTY_EN adds almost_empty and the
//        ALMOST_EMPTY_THRESH parameter.
module fifo_rptr_empty
    import fifo_rptr_empty_pkg::*;
#(
`ifdef FIFO_ALMOST_EMPTY_EN
    parameter int unsigned ALMOST_EMPTY_THRESH = ALMOST_EMPTY_THRESH_DEF,
`endif
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    fifo_rptr_empty_if.slave   bus
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rptr_q;
    logic          empty_q;
    logic [PW-1:0] level_q;
    logic          underflow_q;

    logic          rd_ok;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;

    // Synchronized write pointer back to binary for the level subtraction.
    gray_to_bin #(.WIDTH(PW)) u_wptr_g2b (
        .gray (bus.wptr_sync),
        .bin  (wbin)
    );

    // Next-pointer datapath; empty and level both look at the post-read pointer.
    always_comb begin
        rd_ok      = bus.rd_en & ~empty_q;
        rbin_next  = rbin + PW'(rd_ok);
        rgray_next = (rbin_next >> 1) ^ rbin_next;
        level_next = wbin - rbin_next;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rbin        <= '0;
            rptr_q      <= '0;
            empty_q     <= 1'b1;
            level_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            rbin        <= rbin_next;
            rptr_q      <= rgray_next;
            empty_q     <= (rgray_next == bus.wptr_sync);
            level_q     <= level_next;
            underflow_q <= bus.rd_en & empty_q;
        end
    end

`ifdef FIFO_ALMOST_EMPTY_EN
    logic almost_empty_q;

    // Registered alongside rd_level so the two always agree.
    always_ff @(posedge clk) begin
        if (!rst) begin
            almost_empty_q <= 1'b1;
        end else begin
            almost_empty_q <= (level_next <= PW'(ALMOST_EMPTY_THRESH));
        end
    end

    assign bus.almost_empty = almost_empty_q;
`endif

    assign bus.raddr     = rbin[ADDR_WIDTH-1:0];
    assign bus.rptr      = rptr_q;
    assign bus.empty     = empty_q;
    assign bus.rd_level  = level_q;
    assign bus.underflow = underflow_q;

endmodule : fifo_rptr_empty

// File: tb/tb_fifo_rptr_empty.sv
// Directed bench for fifo_rptr_empty with ADDR_WIDTH=4.
module tb_fifo_rptr_empty;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fifo_rptr_empty_if #(.ADDR_WIDTH(4)) bus ();

    fifo_rptr_empty #(
`ifdef FIFO_ALMOST_EMPTY_EN
        .ALMOST_EMPTY_THRESH(2),
`endif
        .ADDR_WIDTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst           = 1'b0;
        bus.rd_en     = 1'b1;
        bus.wptr_sync = 5'b00010;

        // 1: reset held two edges with rd_en high
        step();
        step();
        check("rst_raddr", 32'(bus.raddr), 32'd0);
        check("rst_rptr", 32'(bus.rptr), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_level", 32'(bus.rd_level), 32'd0);
        check("rst_underflow", 32'(bus.underflow), 32'd0);
`ifdef FIFO_ALMOST_EMPTY_EN
        check("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
`endif

        // 2: three entries become visible, then drain them
        rst       = 1'b1;
        bus.rd_en = 1'b0;
        step();
        check("fill_empty", 32'(bus.empty), 32'd0);
        check("fill_level", 32'(bus.rd_level), 32'd3);
        bus.rd_en = 1'b1;
        step();
        check("rd1_raddr", 32'(bus.raddr), 32'd1);
        check("rd1_rptr", 32'(bus.rptr), 32'b00001);
        check("rd1_empty", 32'(bus.empty), 32'd0);
        check("rd1_level", 32'(bus.rd_level), 32'd2);
        step();
        check("rd2_raddr", 32'(bus.raddr), 32'd2);
        check("rd2_rptr", 32'(bus.rptr), 32'b00011);
        check("rd2_empty", 32'(bus.empty), 32'd0);
        step();
        check("rd3_raddr", 32'(bus.raddr), 32'd3);
        check("rd3_rptr", 32'(bus.rptr), 32'b00010);
        check("rd3_empty", 32'(bus.empty), 32'd1);
        check("rd3_level", 32'(bus.rd_level), 32'd0);

        // 3: read while empty -> single-cycle underflow, pointer frozen
        step();
        check("uf_pulse", 32'(bus.underflow), 32'd1);
        check("uf_rptr", 32'(bus.rptr), 32'b00010);
        check("uf_raddr", 32'(bus.raddr), 32'd3);
        check("uf_level", 32'(bus.rd_level), 32'd0);
        bus.rd_en = 1'b0;
        step();
        check("uf_clear", 32'(bus.underflow), 32'd0);

        // 4: advance rbin to 15 against wptr bin 16, then wrap with a
        //    simultaneous wptr_sync update to bin 20
        bus.wptr_sync = 5'b11000;
        step();
        check("pre_wrap_level", 32'(bus.rd_level), 32'd13);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("pre_wrap_rptr", 32'(bus.rptr), 32'b01000);
        check("pre_wrap_raddr", 32'(bus.raddr), 32'd15);
        bus.wptr_sync = 5'b11110;
        step();
        check("wrap_raddr", 32'(bus.raddr), 32'd0);
        check("wrap_rptr", 32'(bus.rptr), 32'b11000);
        check("wrap_level", 32'(bus.rd_level), 32'd4);
        check("wrap_empty", 32'(bus.empty), 32'd0);
        bus.rd_en = 1'b0;

        // 5: reset in the middle of a burst at rbin=7, wptr bin 10
        rst = 1'b0;
        step();
        rst           = 1'b1;
        bus.wptr_sync = 5'b01111;
        step();
        check("burst_level", 32'(bus.rd_level), 32'd10);
        bus.rd_en = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("burst_rptr", 32'(bus.rptr), 32'b00100);
        rst = 1'b0;
        step();
        check("midrst_rptr", 32'(bus.rptr), 32'd0);
        check("midrst_raddr", 32'(bus.raddr), 32'd0);
        check("midrst_empty", 32'(bus.empty), 32'd1);
        check("midrst_level", 32'(bus.rd_level), 32'd0);
        rst       = 1'b1;
        bus.rd_en = 1'b0;
        step();
        check("post_rst_empty", 32'(bus.empty), 32'd0);
        check("post_rst_level", 32'(bus.rd_level), 32'd10);

        // 6: level 3 drained to 0, watching almost_empty when present
        bus.wptr_sync = 5'b00010;
        step();
        check("ae_level3", 32'(bus.rd_level), 32'd3);
`ifdef FIFO_ALMOST_EMPTY_EN
        check("ae_at3", 32'(bus.almost_empty), 32'd0);
`endif
        bus.rd_en = 1'b1;
        step();
        check("ae_level2", 32'(bus.rd_level), 32'd2);
`ifdef FIFO_ALMOST_EMPTY_EN
        check("ae_at2", 32'(bus.almost_empty), 32'd1);
`endif
        step();
        step();
        check("ae_level0", 32'(bus.rd_level), 32'd0);
        check("ae_empty0", 32'(bus.empty), 32'd1);
`ifdef FIFO_ALMOST_EMPTY_EN
        check("ae_at0", 32'(bus.almost_empty), 32'd1);
`endif
        bus.rd_en = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_rptr_empty
